// File: rtl/fptd_ctrl_pkg.sv
// Shared types for the FPTD section controller.
// Phase encoding matches the Enable pin seen by the section stages.
package fptd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    REPLAY = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  localparam logic PHASE_EVEN = 1'b1;
  localparam logic PHASE_ODD  = 1'b0;

endpackage

// File: rtl/fptd_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached; clear has priority over increment.
module fptd_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fptd_section_sequencer.sv
// Phase/clear sequencer for one pipelined FPTD section.
// Replays a phase on razor error, then flushes and reports done.
module fptd_section_sequencer
  import fptd_ctrl_pkg::*;
#(
  parameter int ITER_W     = 6,
  parameter int FLUSH_CYC  = 4,
  parameter int MAX_REPLAY = 3,
  parameter int RCNT_W     = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              ready,
  input  logic              Error_current_Alpha,
  input  logic              Error_current_be1,
  output logic              Enable,
  output logic              nClear,
  output logic [ITER_W-1:0] iter_idx,
  output logic [RCNT_W-1:0] replay_count,
  output logic              done,
  output logic              abort
);

  localparam int IRW =
    (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;
  localparam int FW =
    (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [IRW-1:0] IR_MAX =
    IRW'(MAX_REPLAY);
  localparam logic [FW-1:0] FL_LAST =
    FW'(FLUSH_CYC - 1);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              enable_d;
  logic              nclear_d;
  logic              done_d;
  logic              abort_d;
  logic              ret_flush;
  logic              ret_flush_d;
  logic [ITER_W-1:0] num_q;
  logic [ITER_W-1:0] num_d;
  logic [ITER_W-1:0] iter_d;
  logic [ITER_W-1:0] iter_nxt;
  logic [FW-1:0]     flush_cnt;
  logic [FW-1:0]     flush_d;
  logic [IRW-1:0]    ir_cnt;
  logic              rc_clr;
  logic              rc_inc;
  logic              ir_clr;
  logic              ir_inc;
  logic              err;

  assign err      = Error_current_Alpha | Error_current_be1;
  assign iter_nxt = iter_idx + ITER_W'(1);

  always_comb begin
    state_d     = state_q;
    enable_d    = Enable;
    nclear_d    = nClear;
    iter_d      = iter_idx;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    num_d       = num_q;
    flush_d     = flush_cnt;
    ret_flush_d = ret_flush;
    rc_clr      = 1'b0;
    rc_inc      = 1'b0;
    ir_clr      = 1'b0;
    ir_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        nclear_d = 1'b0;
        enable_d = 1'b0;
        if (start) begin
          iter_d = '0;
          rc_clr = 1'b1;
          ir_clr = 1'b1;
          if (num_iter != '0) begin
            state_d = CLEAR;
            num_d   = num_iter;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            nclear_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d     = RUN;
        enable_d    = PHASE_EVEN;
        nclear_d    = 1'b1;
        ret_flush_d = 1'b0;
        flush_d     = '0;
      end
      RUN, REPLAY, FLUSH: begin
        nclear_d = 1'b1;
        if (err) begin
          if (ir_cnt == IR_MAX) begin
            state_d  = DONE;
            done_d   = 1'b1;
            abort_d  = 1'b1;
            enable_d = 1'b0;
          end else begin
            // Hold the phase so the stage recomputes it.
            state_d = REPLAY;
            rc_inc  = 1'b1;
            ir_inc  = 1'b1;
          end
        end else begin
          enable_d = ~Enable;
          if (!ret_flush) begin
            state_d = RUN;
            if (Enable == PHASE_ODD) begin
              iter_d = iter_nxt;
              ir_clr = 1'b1;
              if (iter_nxt == num_q) begin
                state_d     = FLUSH;
                ret_flush_d = 1'b1;
                flush_d     = '0;
              end
            end
          end else if (flush_cnt == FL_LAST) begin
            state_d  = DONE;
            done_d   = 1'b1;
            enable_d = 1'b0;
          end else begin
            state_d = FLUSH;
            flush_d = flush_cnt + FW'(1);
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        nclear_d = 1'b0;
        enable_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        nclear_d = 1'b0;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      Enable    <= 1'b0;
      nClear    <= 1'b0;
      iter_idx  <= '0;
      done      <= 1'b0;
      abort     <= 1'b0;
      ready     <= 1'b1;
      num_q     <= '0;
      flush_cnt <= '0;
      ret_flush <= 1'b0;
    end else begin
      state_q   <= state_d;
      Enable    <= enable_d;
      nClear    <= nclear_d;
      iter_idx  <= iter_d;
      done      <= done_d;
      abort     <= abort_d;
      ready     <= (state_d == IDLE);
      num_q     <= num_d;
      flush_cnt <= flush_d;
      ret_flush <= ret_flush_d;
    end
  end

  fptd_sat_counter #(
    .W(RCNT_W)
  ) u_frame_cnt (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (rc_clr),
    .inc  (rc_inc),
    .count(replay_count)
  );

  fptd_sat_counter #(
    .W(IRW)
  ) u_iter_cnt (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (ir_clr),
    .inc  (ir_inc),
    .count(ir_cnt)
  );

endmodule

// File: tb/tb_fptd_section_sequencer.sv
// Scoreboard bench for fptd_section_sequencer.
// Frames push expected done records; a monitor pops them on done.
module tb_fptd_section_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] num_iter = '0;
  logic       ready;
  logic       Error_current_Alpha = 1'b0;
  logic       Error_current_be1 = 1'b0;
  logic       Enable;
  logic       nClear;
  logic [5:0] iter_idx;
  logic [7:0] replay_count;
  logic       done;
  logic       abort;

  fptd_section_sequencer dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .start              (start),
    .num_iter           (num_iter),
    .ready              (ready),
    .Error_current_Alpha(Error_current_Alpha),
    .Error_current_be1  (Error_current_be1),
    .Enable             (Enable),
    .nClear             (nClear),
    .iter_idx           (iter_idx),
    .replay_count       (replay_count),
    .done               (done),
    .abort              (abort)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int cyc;
    int it;
    int rc;
    bit ab;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          ecnt = 0;
  int          acc = 0;
  int          done_cnt = 0;
  int          dc0;
  logic [63:0] en_tr;
  logic [63:0] nc_tr;
  logic [63:0] rdy_tr;
  int          it_tr[64];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge Clock);
    ecnt++;
    #2;
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", ecnt - acc + 1, e.cyc);
        chk("done_iter", iter_idx, e.it);
        chk("done_rcnt", replay_count, e.rc);
        chk("done_abort", abort, e.ab);
        chk("done_enable", Enable, 0);
      end
    end
    if (abort && !done) chk("abort_alone", abort, 0);
  end

  task automatic run_frame(input int n,
                           input logic [63:0] am,
                           input logic [63:0] bm,
                           input int rst_cyc,
                           input bit hold,
                           input int exp_cyc,
                           input int exp_rc,
                           input int exp_it,
                           input bit exp_ab);
    bit   seen;
    exp_t e;
    e = '{exp_cyc, exp_it, exp_rc, exp_ab};
    if (rst_cyc == 0) sbq.push_back(e);
    en_tr  = '0;
    nc_tr  = '0;
    rdy_tr = '0;
    @(negedge Clock);
    start    = 1'b1;
    num_iter = 6'(n);
    @(posedge Clock);
    #1;
    acc = ecnt;
    if (hold) num_iter = 6'd1;
    else start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < 64; k++) begin
      @(negedge Clock);
      Error_current_Alpha = am[k];
      Error_current_be1   = bm[k];
      en_tr[k]  = Enable;
      nc_tr[k]  = nClear;
      rdy_tr[k] = ready;
      it_tr[k]  = int'(iter_idx);
      if (k == rst_cyc) begin
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        seen  = 1'b1;
        break;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    Error_current_Alpha = 1'b0;
    Error_current_be1   = 1'b0;
    if (hold) begin
      @(negedge Clock);
      start = 1'b0;
    end
    chk("frame_timeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_nclear", nClear, 0);
    chk("rst_enable", Enable, 0);
    chk("rst_iter", iter_idx, 0);
    chk("rst_rcnt", replay_count, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    @(negedge Clock);
    Reset = 1'b0;

    run_frame(3, 0, 0, 0, 0, 12, 0, 3, 0);
    chk("t1_nclear_c1", nc_tr[1], 0);
    chk("t1_nclear_c2", nc_tr[2], 1);
    chk("t1_ready_c1", rdy_tr[1], 0);
    chk("t1_en_run", en_tr[7:2], 6'b010101);
    chk("t1_iter_c4", it_tr[4], 1);
    chk("t1_iter_c6", it_tr[6], 2);
    chk("t1_iter_c8", it_tr[8], 3);
    chk("t1_en_flush", en_tr[11:8], 4'b0101);
    @(negedge Clock);
    chk("t1_ready_after", ready, 1);

    run_frame(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t0_enable", en_tr[1], 0);
    chk("t0_iter", it_tr[1], 0);

    run_frame(2, 64'h8, 0, 0, 0, 11, 1, 2, 0);
    chk("t2_en", en_tr[4:2], 3'b001);
    chk("t2_iter_c4", it_tr[4], 0);
    chk("t2_iter_c5", it_tr[5], 1);
    chk("t2_iter_c7", it_tr[7], 2);

    run_frame(1, 0, 64'h3C, 0, 0, 6, 3, 0, 1);
    chk("t3_en", en_tr[5:2], 4'hF);
    chk("t3_iter_c5", it_tr[5], 0);

    dc0 = done_cnt;
    run_frame(5, 0, 0, 0, 1, 16, 0, 5, 0);
    repeat (3) @(negedge Clock);
    chk("busy_ready", ready, 1);
    chk("busy_nclear", nClear, 0);
    chk("busy_done_cnt", done_cnt - dc0, 1);

    dc0 = done_cnt;
    run_frame(5, 0, 0, 6, 0, 0, 0, 0, 0);
    chk("rst_mid_iter_c6", it_tr[6], 2);
    chk("rst_mid_nclear", nClear, 0);
    chk("rst_mid_enable", Enable, 0);
    chk("rst_mid_iter", iter_idx, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_done", done, 0);
    repeat (4) @(negedge Clock);
    chk("rst_mid_no_done", done_cnt - dc0, 0);

    run_frame(1, 64'h20, 0, 0, 0, 9, 1, 1, 0);
    chk("tf_en", en_tr[8:4], 5'b01001);
    chk("tf_iter_c4", it_tr[4], 1);

    repeat (3) @(negedge Clock);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
